// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle shift-add
// unsigned multiplier. All results are registered; done pulses when they update.
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             ExternalReset,
   input  logic             start,
   input  logic [9:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] aluout,
   output logic [WIDTH-1:0] mulhi,
   output logic             cout,
   output logic             zout,
   output logic             err,
   output logic [0:0]       dbg_state_o
);

   localparam logic [9:0] OP_B15TO0 = 10'b10_0000_0000;
   localparam logic [9:0] OP_AND    = 10'b01_0000_0000;
   localparam logic [9:0] OP_OR     = 10'b00_1000_0000;
   localparam logic [9:0] OP_NOTB   = 10'b00_0100_0000;
   localparam logic [9:0] OP_SHL    = 10'b00_0010_0000;
   localparam logic [9:0] OP_SHR    = 10'b00_0001_0000;
   localparam logic [9:0] OP_ADD    = 10'b00_0000_1000;
   localparam logic [9:0] OP_SUB    = 10'b00_0000_0100;
   localparam logic [9:0] OP_MUL    = 10'b00_0000_0010;
   localparam logic [9:0] OP_CMP    = 10'b00_0000_0001;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   logic [0:0]         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0]   aluout_q, aluout_d;
   logic [WIDTH-1:0]   mulhi_q,  mulhi_d;
   logic               cout_q,   cout_d;
   logic               zout_q,   zout_d;
   logic               err_q,    err_d;
   logic               done_q,   done_d;

   logic               op_legal;
   logic [WIDTH:0]     alu_res;
   logic [2*WIDTH-1:0] acc_step;

   assign op_legal = (op != 10'd0) && ((op & (op - 10'd1)) == 10'd0);

   // {carry/flag, result} for every single-cycle op
   always_comb begin
      alu_res = '0;
      case (op)
         OP_B15TO0: alu_res = {1'b0, B};
         OP_AND:    alu_res = {1'b0, A & B};
         OP_OR:     alu_res = {1'b0, A | B};
         OP_NOTB:   alu_res = {1'b0, ~B};
         OP_SHL:    alu_res = {B[WIDTH-1], B << 1};
         OP_SHR:    alu_res = {B[0], B >> 1};
         OP_ADD:    alu_res = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
         OP_SUB:    alu_res = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin};
         OP_CMP:    alu_res = {(A > B), A};
         default:   alu_res = '0;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      aluout_d = aluout_q;
      mulhi_d  = mulhi_q;
      cout_d   = cout_q;
      zout_d   = zout_q;
      err_d    = err_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  state_d  = S_MUL;
                  cnt_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = B;
                  acc_d    = '0;
                  err_d    = 1'b0;
               end else if (op_legal) begin
                  aluout_d = alu_res[WIDTH-1:0];
                  mulhi_d  = '0;
                  cout_d   = alu_res[WIDTH];
                  zout_d   = (alu_res[WIDTH-1:0] == '0);
                  err_d    = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  aluout_d = '0;
                  mulhi_d  = '0;
                  cout_d   = 1'b0;
                  zout_d   = 1'b1;
                  err_d    = 1'b1;
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // Final iteration publishes the sum including this step's partial product
            if (cnt_q == CNT_LAST) begin
               state_d  = S_IDLE;
               aluout_d = acc_step[WIDTH-1:0];
               mulhi_d  = acc_step[2*WIDTH-1:WIDTH];
               cout_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
               zout_d   = (acc_step == '0);
               done_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge ExternalReset) begin
      if (ExternalReset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         aluout_q <= '0;
         mulhi_q  <= '0;
         cout_q   <= 1'b0;
         zout_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         aluout_q <= aluout_d;
         mulhi_q  <= mulhi_d;
         cout_q   <= cout_d;
         zout_q   <= zout_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign busy        = (state_q == S_MUL);
   assign done        = done_q;
   assign aluout      = aluout_q;
   assign mulhi       = mulhi_q;
   assign cout        = cout_q;
   assign zout        = zout_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): hand-computed vectors for every op,
// multiply latency/busy timing, busy-time start rejection and mid-multiply reset.
module tb_seq_alu;

   localparam logic [9:0] OP_B15TO0 = 10'b10_0000_0000;
   localparam logic [9:0] OP_AND    = 10'b01_0000_0000;
   localparam logic [9:0] OP_OR     = 10'b00_1000_0000;
   localparam logic [9:0] OP_NOTB   = 10'b00_0100_0000;
   localparam logic [9:0] OP_SHL    = 10'b00_0010_0000;
   localparam logic [9:0] OP_SHR    = 10'b00_0001_0000;
   localparam logic [9:0] OP_ADD    = 10'b00_0000_1000;
   localparam logic [9:0] OP_SUB    = 10'b00_0000_0100;
   localparam logic [9:0] OP_MUL    = 10'b00_0000_0010;
   localparam logic [9:0] OP_CMP    = 10'b00_0000_0001;

   logic        clk = 1'b0;
   logic        ExternalReset;
   logic        start;
   logic [9:0]  op;
   logic [15:0] A;
   logic [15:0] B;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] aluout;
   logic [15:0] mulhi;
   logic        cout;
   logic        zout;
   logic        err;
   logic [0:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   seq_alu #(.WIDTH(16)) dut (
      .clk           (clk),
      .ExternalReset (ExternalReset),
      .start         (start),
      .op            (op),
      .A             (A),
      .B             (B),
      .cin           (cin),
      .busy          (busy),
      .done          (done),
      .aluout        (aluout),
      .mulhi         (mulhi),
      .cout          (cout),
      .zout          (zout),
      .err           (err),
      .dbg_state_o   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Drives one start cycle; returns just after the accepting edge.
   task automatic issue(input logic [9:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
      op    = o;
      A     = a;
      B     = b;
      cin   = c;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic expect_res(input string tag, input logic [15:0] e_alu, input logic [15:0] e_hi,
                             input logic e_c, input logic e_z, input logic e_err);
      check({tag, ".aluout"}, 32'(aluout), 32'(e_alu));
      check({tag, ".mulhi"},  32'(mulhi),  32'(e_hi));
      check({tag, ".cout"},   32'(cout),   32'(e_c));
      check({tag, ".zout"},   32'(zout),   32'(e_z));
      check({tag, ".err"},    32'(err),    32'(e_err));
      check({tag, ".done"},   32'(done),   32'd1);
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk);
      #1;
      check({tag, ".done_drop"}, 32'(done), 32'd0);
      check({tag, ".busy_idle"}, 32'(busy), 32'd0);
   endtask

   // Multiply with latency measured in edges from the accepting edge to done, inclusive.
   task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit inject, input logic [15:0] hold_alu,
                          output int lat, output int bcyc);
      issue(OP_MUL, a, b, 1'b0);
      lat  = 1;
      bcyc = busy ? 1 : 0;
      while (!done && lat < 40) begin
         if (inject && lat == 5) begin
            op    = OP_ADD;
            A     = 16'h0001;
            B     = 16'h0001;
            start = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
         if (busy) bcyc++;
         if (inject && lat == 6) begin
            check({tag, ".hold_alu"},  32'(aluout), 32'(hold_alu));
            check({tag, ".no_done"},   32'(done),   32'd0);
            check({tag, ".still_busy"}, 32'(busy),  32'd1);
         end
      end
   endtask

   initial begin
      int lat;
      int bcyc;
      ExternalReset = 1'b1;
      start = 1'b0;
      op    = '0;
      A     = '0;
      B     = '0;
      cin   = 1'b0;
      #1;
      check("rst.busy",   32'(busy),   32'd0);
      check("rst.done",   32'(done),   32'd0);
      check("rst.aluout", 32'(aluout), 32'd0);
      check("rst.mulhi",  32'(mulhi),  32'd0);
      check("rst.cout",   32'(cout),   32'd0);
      check("rst.zout",   32'(zout),   32'd0);
      check("rst.err",    32'(err),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      ExternalReset = 1'b0;
      @(posedge clk);
      #1;

      issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
      expect_res("add_wrap", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("add_wrap.busy", 32'(busy), 32'd0);
      idle_cycle("add_wrap");
      check("add_wrap.hold", 32'(aluout), 32'h0000);

      issue(OP_ADD, 16'h1234, 16'h1111, 1'b1);
      expect_res("add_cin", 16'h2346, 16'h0000, 1'b0, 1'b0, 1'b0);
      // back-to-back: accepted while done is high
      issue(OP_SUB, 16'h0003, 16'h0005, 1'b1);
      expect_res("sub_borrow", 16'hFFFD, 16'h0000, 1'b1, 1'b0, 1'b0);
      issue(OP_CMP, 16'h0007, 16'h0002, 1'b0);
      expect_res("cmp_gt", 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0);
      issue(OP_CMP, 16'h0005, 16'h0005, 1'b0);
      expect_res("cmp_eq", 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
      issue(OP_SUB, 16'h0005, 16'h0003, 1'b0);
      expect_res("sub_nob", 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
      issue(OP_SHL, 16'h0000, 16'h8001, 1'b0);
      expect_res("shl", 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
      issue(OP_SHR, 16'h0000, 16'h0001, 1'b0);
      expect_res("shr", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
      issue(OP_AND, 16'hF0F0, 16'hFF00, 1'b1);
      expect_res("and", 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b0);
      issue(OP_NOTB, 16'hAAAA, 16'h00FF, 1'b0);
      expect_res("notb", 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b0);
      issue(OP_B15TO0, 16'hFFFF, 16'h1234, 1'b0);
      expect_res("passb", 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
      idle_cycle("passb");

      issue(10'b00_0000_0011, 16'h1234, 16'h5678, 1'b0);
      expect_res("illegal2", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      issue(10'b00_0000_0000, 16'h1234, 16'h5678, 1'b0);
      expect_res("illegal0", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
      issue(OP_OR, 16'h00F0, 16'h0F00, 1'b0);
      expect_res("or", 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0);
      idle_cycle("or");

      run_mul("mul_max", 16'hFFFF, 16'hFFFF, 1'b1, 16'h0FF0, lat, bcyc);
      check("mul_max.latency", 32'(lat),  32'd17);
      check("mul_max.busy_cyc", 32'(bcyc), 32'd16);
      expect_res("mul_max", 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0);
      check("mul_max.busy_end", 32'(busy), 32'd0);
      issue(OP_AND, 16'h0F0F, 16'h00FF, 1'b0);
      expect_res("and_after_mul", 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
      idle_cycle("and_after_mul");

      run_mul("mul_hi", 16'h0100, 16'h0100, 1'b0, 16'h0000, lat, bcyc);
      check("mul_hi.latency", 32'(lat), 32'd17);
      expect_res("mul_hi", 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
      run_mul("mul_zero", 16'h0000, 16'h1234, 1'b0, 16'h0000, lat, bcyc);
      expect_res("mul_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      idle_cycle("mul_zero");

      issue(OP_B15TO0, 16'h0000, 16'hBEEF, 1'b0);
      issue(OP_MUL, 16'h1234, 16'h5678, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("rst_mul.busy_before", 32'(busy), 32'd1);
      #2;
      ExternalReset = 1'b1;
      #1;
      check("rst_mul.busy",   32'(busy),   32'd0);
      check("rst_mul.done",   32'(done),   32'd0);
      check("rst_mul.aluout", 32'(aluout), 32'd0);
      check("rst_mul.mulhi",  32'(mulhi),  32'd0);
      check("rst_mul.cout",   32'(cout),   32'd0);
      check("rst_mul.zout",   32'(zout),   32'd0);
      check("rst_mul.err",    32'(err),    32'd0);
      @(posedge clk);
      #1;
      ExternalReset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) check("rst_mul.stale_done", 32'(done), 32'd0);
      end
      check("rst_mul.idle_busy", 32'(busy), 32'd0);

      run_mul("mul_small", 16'h0003, 16'h0004, 1'b0, 16'h0000, lat, bcyc);
      check("mul_small.latency", 32'(lat),  32'd17);
      check("mul_small.busy_cyc", 32'(bcyc), 32'd16);
      expect_res("mul_small", 16'h000C, 16'h0000, 1'b0, 1'b0, 1'b0);
      idle_cycle("mul_small");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
